matriz_addsub_seq: RTL and testbench

Parametrised, multi-cycle matrix add/subtract unit for the coprocessor ULA. It supersedes the single-cycle element-wise subtractor. It takes two packed N×N matrices, processes LANES elements per clock, and supports add or subtract in wrap or signed-saturating mode. It reports a sticky signed-overflow flag and uses a start/busy/done handshake toward the coprocessor control FSM.

---
 rtl/matriz_addsub_seq.sv | 144 ++++++++++++++
 tb/tb_matriz_addsub_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/matriz_addsub_seq.sv
// ---------------------------------------------------------------------------
// matriz_addsub_seq
// Multi-cycle N x N matrix add/subtract unit. Processes LANES elements per
// clock in wrap or signed-saturating mode. A sticky flag reports whether any
// element overflowed. A start/busy/done handshake connects the unit to the
// coprocessor control FSM.
//
// Ports
//   clk                : system clock, rising edge
//   rst_n              : asynchronous active-low reset
//   start              : request an operation (sampled only in IDLE)
//   op                 : 00 add-wrap, 01 sub-wrap, 10 add-sat, 11 sub-sat
//   matrizA, matrizB   : packed operands, element i at [i*W +: W]
//   matriz_resultante  : result register, same packing
//   busy               : high while the element groups are being computed
//   done               : one-cycle pulse when the result is complete
//   overflow           : sticky signed overflow of the last operation
// ---------------------------------------------------------------------------
module matriz_addsub_seq #(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int LANES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [N*N*W-1:0]   matrizA,
    input  logic [N*N*W-1:0]   matrizB,
    output logic [N*N*W-1:0]   matriz_resultante,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int NE = N * N;
    // Wide enough to hold idx + LANES past the last element without wrapping.
    localparam int IW = $clog2(NE + LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [NE*W-1:0]   a_reg;
    logic [NE*W-1:0]   b_reg;
    logic [1:0]        op_reg;
    logic [IW-1:0]     idx;
    logic              last_group;

    logic [IW-1:0]       lane_pos [LANES];
    logic signed [W:0]   lane_sum [LANES];
    logic [W-1:0]        lane_res [LANES];
    logic [LANES-1:0]    lane_ok;
    logic [LANES-1:0]    lane_ovf;

    // Outputs are pure decodes of the state register, so nothing combinational
    // reaches them from the inputs.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    assign last_group = (int'(idx) + LANES >= NE);

    // NOTE: state elements use non-blocking assignments so that every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)      next_state = S_RUN;
            S_RUN:   if (last_group) next_state = S_DONE;
            S_DONE:                  next_state = S_IDLE;
            default:                 next_state = S_IDLE;
        endcase
    end

    // Per-lane arithmetic in W+1 bits. Lanes past the last element are masked
    // so a partial final group neither writes nor flags overflow.
    always_comb begin
        lane_ok  = '0;
        lane_ovf = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_pos[l] = idx + IW'(l);
            lane_ok[l]  = (int'(lane_pos[l]) < NE);
            if (op_reg[0])
                lane_sum[l] = $signed({a_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W + W-1],
                                       a_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W +: W]})
                            - $signed({b_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W + W-1],
                                       b_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W +: W]});
            else
                lane_sum[l] = $signed({a_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W + W-1],
                                       a_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W +: W]})
                            + $signed({b_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W + W-1],
                                       b_reg[(lane_ok[l] ? int'(lane_pos[l]) : 0)*W +: W]});
            // Signed overflow: the two top bits of the W+1 bit result disagree.
            lane_ovf[l] = lane_ok[l] & (lane_sum[l][W] ^ lane_sum[l][W-1]);
            if (op_reg[1] && (lane_sum[l][W] ^ lane_sum[l][W-1]))
                lane_res[l] = lane_sum[l][W] ? {1'b1, {(W-1){1'b0}}}
                                             : {1'b0, {(W-1){1'b1}}};
            else
                lane_res[l] = lane_sum[l][W-1:0];
        end
    end

    // NOTE: the captured operands are reset along with the result so the
    // datapath never computes from X after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg             <= '0;
            b_reg             <= '0;
            op_reg            <= '0;
            idx               <= '0;
            overflow          <= 1'b0;
            matriz_resultante <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= matrizA;
                        b_reg    <= matrizB;
                        op_reg   <= op;
                        idx      <= '0;
                        overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_ok[l])
                            matriz_resultante[int'(lane_pos[l])*W +: W] <= lane_res[l];
                    end
                    overflow <= overflow | (|lane_ovf);
                    idx      <= idx + IW'(LANES);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matriz_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_matriz_addsub_seq
// Self-checking bench for matriz_addsub_seq. Two instances share clock,
// reset and operand buses: one with LANES=5 (five full groups) and one with
// LANES=7 (partial last group). Expected results come from a behavioural
// model and are queued when an operation is launched, then popped when done
// pulses.
// ---------------------------------------------------------------------------
module tb_matriz_addsub_seq;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int MW = NE * W;

    typedef struct {
        logic [MW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start5 = 1'b0;
    logic          start7 = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [MW-1:0] mat_a = '0;
    logic [MW-1:0] mat_b = '0;
    logic [MW-1:0] res5, res7, res_s;
    logic          busy5, busy7, busy_s;
    logic          done5, done7, done_s;
    logic          ovf5, ovf7, ovf_s;
    bit            cur_sel = 1'b0;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    matriz_addsub_seq #(.N(N), .W(W), .LANES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .op(op),
        .matrizA(mat_a), .matrizB(mat_b),
        .matriz_resultante(res5), .busy(busy5), .done(done5), .overflow(ovf5)
    );

    matriz_addsub_seq #(.N(N), .W(W), .LANES(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .op(op),
        .matrizA(mat_a), .matrizB(mat_b),
        .matriz_resultante(res7), .busy(busy7), .done(done7), .overflow(ovf7)
    );

    assign res_s  = cur_sel ? res7  : res5;
    assign busy_s = cur_sel ? busy7 : busy5;
    assign done_s = cur_sel ? done7 : done5;
    assign ovf_s  = cur_sel ? ovf7  : ovf5;

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
        logic [MW-1:0] m;
        for (int i = 0; i < NE; i++) m[i*W +: W] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < NE; i++) m[i*W +: W] = W'($urandom);
        return m;
    endfunction

    // Reference: integer arithmetic with explicit range test and clamp.
    function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                   input logic [1:0] o);
        exp_t e;
        int   sa, sb_v, r;
        e.ovf = 1'b0;
        e.res = '0;
        for (int i = 0; i < NE; i++) begin
            sa   = int'($signed(a[i*W +: W]));
            sb_v = int'($signed(b[i*W +: W]));
            r    = o[0] ? sa - sb_v : sa + sb_v;
            if (r > 127 || r < -128) begin
                e.ovf = 1'b1;
                if (o[1]) r = (r > 127) ? 127 : -128;
            end
            e.res[i*W +: W] = W'(r);
        end
        return e;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start7 = v;
        else     start5 = v;
    endtask

    // Launch one operation on the chosen instance and check handshake timing
    // and result. With inject set, a different request is pulsed mid-RUN.
    task automatic run_op(input string tag, input bit sel, input logic [MW-1:0] a,
                          input logic [MW-1:0] b, input logic [1:0] o, input bit inject);
        exp_t e;
        int   busy_cnt;
        bit   got;
        int   k;
        k        = sel ? 4 : 5;
        busy_cnt = 0;
        got      = 1'b0;
        cur_sel  = sel;
        sb.push_back(model(a, b, o));
        @(negedge clk);
        mat_a = a; mat_b = b; op = o;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (done_s) begin
                got = 1'b1;
                break;
            end
            if (busy_s) busy_cnt++;
            if (inject && c == 1) begin
                mat_a = ~a; mat_b = a; op = ~o;
                set_start(sel, 1'b1);
            end else if (inject && c == 2) begin
                set_start(sel, 1'b0);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, MW'(got), MW'(1));
        check({tag, "_busy_cycles"}, MW'(busy_cnt), MW'(k));
        check({tag, "_busy_at_done"}, MW'(busy_s), MW'(0));
        check({tag, "_result"}, res_s, e.res);
        check({tag, "_overflow"}, MW'(ovf_s), MW'(e.ovf));
        @(negedge clk);
        check({tag, "_done_single"}, MW'({done_s, busy_s}), MW'(0));
    endtask

    initial begin
        logic [MW-1:0] ra, rb;

        // Reset state.
        #12;
        check("rst_result", res5, '0);
        check("rst_busy", MW'({busy5, busy7}), MW'(0));
        check("rst_done", MW'({done5, done7}), MW'(0));
        check("rst_overflow", MW'({ovf5, ovf7}), MW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtract, no overflow.
        run_op("sub_wrap_basic", 1'b0, fill(8'd10), fill(8'd3), 2'b01, 1'b0);
        // Add overflow: wrap then saturate.
        run_op("add_wrap_ovf", 1'b0, fill(8'd100), fill(8'd100), 2'b00, 1'b0);
        run_op("add_sat_ovf", 1'b0, fill(8'd100), fill(8'd100), 2'b10, 1'b0);
        // Negative boundary: -128 - 1.
        ra = '0; ra[7:0] = 8'h80;
        rb = '0; rb[7:0] = 8'h01;
        run_op("sub_sat_min", 1'b0, ra, rb, 2'b11, 1'b0);
        run_op("sub_wrap_min", 1'b0, ra, rb, 2'b01, 1'b0);
        // Partial last group with seven lanes, random operands.
        run_op("lanes7_rand", 1'b1, rnd_mat(), rnd_mat(), 2'b01, 1'b0);
        run_op("lanes7_rand_sat", 1'b1, rnd_mat(), rnd_mat(), 2'b10, 1'b0);
        // Start pulsed mid-RUN is ignored.
        run_op("start_ignored", 1'b0, rnd_mat(), rnd_mat(), 2'b01, 1'b1);
        check("no_queued_op", MW'({busy5, done5}), MW'(0));

        // Asynchronous reset between clock edges in the middle of RUN.
        cur_sel = 1'b0;
        @(negedge clk);
        mat_a = fill(8'd100); mat_b = fill(8'd100); op = 2'b00;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        @(negedge clk);
        check("pre_rst_ovf", MW'({busy5, ovf5}), MW'(3));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy_done_ovf", MW'({busy5, done5, ovf5}), MW'(0));
        check("mid_rst_result", res5, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 1'b0, rnd_mat(), rnd_mat(), 2'b11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
